trap_arbiter: RTL and testbench

//  Trap scheduler in front of the CSR/exception unit. Arbitrates synchronous exceptions against

---
 rtl/trap_arbiter_if.sv | 33 +++
 rtl/trap_arbiter.sv | 99 +++++++++
 tb/tb_trap_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/trap_arbiter_if.sv
// trap_arbiter_if: CSR-side and FSM-side signals of the trap arbiter.
//   master: control unit / CSR unit side, drives the requests and CSR state.
//   slave : trap_arbiter side, drives exception_event, cause, badaddr,
//           irq_pending, stall and wfi_active.
interface trap_arbiter_if;
  logic [31:0] mstatus;
  logic [31:0] mie;
  logic [31:0] mip;
  logic [1:0]  privilege_mode;
  logic        irq_ext;
  logic        inst_boundary;
  logic        exc_valid;
  logic [31:0] exc_cause;
  logic [31:0] exc_badaddr;
  logic        wfi_req;
  logic        trap_ack;
  logic        exception_event;
  logic [31:0] cause;
  logic [31:0] badaddr;
  logic        irq_pending;
  logic        stall;
  logic        wfi_active;
  modport master (
    output mstatus, mie, mip, privilege_mode, irq_ext, inst_boundary,
           exc_valid, exc_cause, exc_badaddr, wfi_req, trap_ack,
    input  exception_event, cause, badaddr, irq_pending, stall, wfi_active
  );
  modport slave (
    input  mstatus, mie, mip, privilege_mode, irq_ext, inst_boundary,
           exc_valid, exc_cause, exc_badaddr, wfi_req, trap_ack,
    output exception_event, cause, badaddr, irq_pending, stall, wfi_active
  );
endinterface

// File: rtl/trap_arbiter.sv
// trap_arbiter: arbitrates synchronous exceptions against MEI/MSI/MTI, issues one trap strobe and sequences WFI.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : trap_arbiter_if.slave (CSR state, FSM requests, trap outputs)
// Optional: define TRAP_IRQ_SYNC_EN to pass irq_ext through IRQ_SYNC_STAGES flops.
module trap_arbiter #(
  parameter int          IRQ_SYNC_STAGES = 2,
  parameter int unsigned WFI_TIMEOUT     = 0
) (
  input logic           clk,
  input logic           resetn,
  trap_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WFI} state_t;
  state_t      state, state_nx;
  logic        irq_ext_eff;
  logic [2:0]  pend;
  logic        any_pend;
  logic        gie;
  logic [4:0]  irq_code;
  logic        ack_early, ack_early_nx;
  logic [31:0] cnt, cnt_nx;
  logic [31:0] cause_nx, badaddr_nx;
  logic        unused_bits;
`ifdef TRAP_IRQ_SYNC_EN
  logic [IRQ_SYNC_STAGES-1:0] sync;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) sync <= '0;
    else begin
      sync[0] <= bus.irq_ext;
      for (int i = 1; i < IRQ_SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  assign irq_ext_eff = sync[IRQ_SYNC_STAGES-1];
`else
  localparam int unused_sync_stages = IRQ_SYNC_STAGES;
  assign irq_ext_eff = bus.irq_ext;
`endif
  assign unused_bits = ^{bus.mstatus[31:4], bus.mstatus[2:0], bus.mie[31:12], bus.mie[10:8],
                         bus.mie[6:4], bus.mie[2:0], bus.mip[31:8], bus.mip[6:4], bus.mip[2:0]};
  // pend = {MEI, MSI, MTI}, already in priority order
  assign pend     = {bus.mie[11] & irq_ext_eff, bus.mie[3] & bus.mip[3], bus.mie[7] & bus.mip[7]};
  assign any_pend = |pend;
  assign gie      = bus.mstatus[3] | (bus.privilege_mode != 2'd3);
  assign irq_code = pend[2] ? 5'd11 : pend[1] ? 5'd3 : 5'd7;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx     = state;
    cause_nx     = bus.cause;
    badaddr_nx   = bus.badaddr;
    cnt_nx       = (state == WFI) ? cnt + 32'd1 : cnt;
    ack_early_nx = 1'b0;
    case (state)
      IDLE:
        if (bus.exc_valid) begin
          state_nx   = ISSUE;
          cause_nx   = bus.exc_cause;
          badaddr_nx = bus.exc_badaddr;
        end else if (bus.inst_boundary & gie & any_pend) begin
          state_nx   = ISSUE;
          cause_nx   = {1'b1, 26'b0, irq_code};
          badaddr_nx = '0;
        end else if (bus.wfi_req) begin
          state_nx = WFI;
          cnt_nx   = '0;
        end
      // an ack arriving together with the strobe is remembered so WAIT_ACK lasts one cycle
      ISSUE: begin
        state_nx     = WAIT_ACK;
        ack_early_nx = bus.trap_ack;
      end
      WAIT_ACK: state_nx = (bus.trap_ack | ack_early) ? IDLE : WAIT_ACK;
      WFI: state_nx = (any_pend || (WFI_TIMEOUT != 0 && cnt == WFI_TIMEOUT)) ? IDLE : WFI;
      default: state_nx = IDLE;
    endcase
  end
  // outputs are registered copies of what the next state implies
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt                 <= '0;
      ack_early           <= 1'b0;
      bus.exception_event <= 1'b0;
      bus.cause           <= '0;
      bus.badaddr         <= '0;
      bus.irq_pending     <= 1'b0;
      bus.stall           <= 1'b0;
      bus.wfi_active      <= 1'b0;
    end else begin
      cnt                 <= cnt_nx;
      ack_early           <= ack_early_nx;
      bus.exception_event <= state_nx == ISSUE;
      bus.cause           <= cause_nx;
      bus.badaddr         <= badaddr_nx;
      bus.irq_pending     <= any_pend;
      bus.stall           <= (state_nx == WAIT_ACK) || (state_nx == WFI);
      bus.wfi_active      <= state_nx == WFI;
    end
endmodule

// File: tb/tb_trap_arbiter.sv
// tb_trap_arbiter: directed stimulus, per-cycle reference model comparison and literal spot checks.
module tb_trap_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  trap_arbiter_if bus();
  trap_arbiter dut (.clk(clk), .resetn(resetn), .bus(bus));
  localparam int unsigned TIMEOUT = 0;
  bit          m_ev = 0, m_stall = 0, m_wfi = 0, m_irqp = 0, m_ack = 0;
  int unsigned m_slept = 0;
  logic [31:0] m_cause = '0, m_bad = '0;
`ifdef TRAP_IRQ_SYNC_EN
  bit [1:0] m_hist = '0;
`endif
  // reference: tracks "trap in flight", "acked with strobe" and "asleep" as plain flags
  always @(posedge clk or negedge resetn) begin
    bit eff, p11, p3, p7, any, gie;
    if (!resetn) begin
      m_ev = 0; m_stall = 0; m_wfi = 0; m_irqp = 0; m_ack = 0; m_slept = 0;
      m_cause = '0; m_bad = '0;
`ifdef TRAP_IRQ_SYNC_EN
      m_hist = '0;
`endif
    end else begin
`ifdef TRAP_IRQ_SYNC_EN
      eff = m_hist[1];
      m_hist = {m_hist[0], bus.irq_ext};
`else
      eff = bus.irq_ext;
`endif
      p11 = bus.mie[11] & eff;
      p3  = bus.mie[3] & bus.mip[3];
      p7  = bus.mie[7] & bus.mip[7];
      any = p11 | p3 | p7;
      gie = bus.mstatus[3] || bus.privilege_mode != 2'd3;
      m_irqp = any;
      if (m_ev) begin
        m_ev = 0; m_stall = 1; m_ack = bus.trap_ack;
      end else if (m_wfi) begin
        if (any || (TIMEOUT != 0 && m_slept == TIMEOUT)) begin m_wfi = 0; m_stall = 0; end
        else m_slept++;
      end else if (m_stall) begin
        if (bus.trap_ack || m_ack) begin m_stall = 0; m_ack = 0; end
      end else if (bus.exc_valid) begin
        m_ev = 1; m_cause = bus.exc_cause; m_bad = bus.exc_badaddr;
      end else if (bus.inst_boundary && gie && any) begin
        m_ev = 1; m_cause = 32'h8000_0000 | 32'(p11 ? 11 : p3 ? 3 : 7); m_bad = '0;
      end else if (bus.wfi_req) begin
        m_wfi = 1; m_stall = 1; m_slept = 0;
      end
    end
  end
  always @(negedge clk) begin
    checks++;
    if ({bus.exception_event, bus.stall, bus.wfi_active, bus.irq_pending, bus.cause, bus.badaddr} !==
        {m_ev, m_stall, m_wfi, m_irqp, m_cause, m_bad}) begin
      errors++;
      $display("FAIL model ev/stall/wfi/irqp cause badaddr: got %b%b%b%b %h %h expected %b%b%b%b %h %h",
               bus.exception_event, bus.stall, bus.wfi_active, bus.irq_pending, bus.cause, bus.badaddr,
               m_ev, m_stall, m_wfi, m_irqp, m_cause, m_bad);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  task automatic clr();
    bus.mstatus = '0; bus.mie = '0; bus.mip = '0; bus.privilege_mode = 2'd3; bus.irq_ext = 0;
    bus.inst_boundary = 0; bus.exc_valid = 0; bus.exc_cause = '0; bus.exc_badaddr = '0;
    bus.wfi_req = 0; bus.trap_ack = 0;
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    clr();
    step(); step();
    chk("reset_stall", 32'(bus.stall), 0);
    chk("reset_cause", bus.cause, 0);
    chk("reset_event", 32'(bus.exception_event), 0);
    #1 resetn = 1;
    step();
    // exception in IDLE, then one ignored in WAIT_ACK
    #1 bus.exc_valid = 1; bus.exc_cause = 32'd2; bus.exc_badaddr = 32'h1234;
    step();
    chk("t1_event", 32'(bus.exception_event), 1);
    chk("t1_cause", bus.cause, 32'd2);
    chk("t1_badaddr", bus.badaddr, 32'h1234);
    #1 bus.exc_valid = 0;
    step();
    chk("t1_event_once", 32'(bus.exception_event), 0);
    chk("t1_stall", 32'(bus.stall), 1);
    #1 bus.exc_valid = 1; bus.exc_cause = 32'd9;
    step();
    chk("t1_cause_held", bus.cause, 32'd2);
    #1 bus.exc_valid = 0; bus.trap_ack = 1;
    step();
    chk("t1_stall_release", 32'(bus.stall), 0);
    #1 bus.trap_ack = 0;
    // MTI at a boundary, acked in the strobe cycle
    bus.mstatus = 32'h8; bus.mie = 32'h80; bus.mip = 32'h80; bus.inst_boundary = 1;
    step();
    chk("t2_event", 32'(bus.exception_event), 1);
    chk("t2_cause", bus.cause, 32'h8000_0007);
    chk("t2_badaddr", bus.badaddr, 0);
    chk("t2_irqp", 32'(bus.irq_pending), 1);
    #1 bus.inst_boundary = 0; bus.mip = '0; bus.trap_ack = 1;
    step();
    chk("t2_wait", 32'(bus.stall), 1);
    #1 bus.trap_ack = 0;
    step();
    chk("t2_early_ack", 32'(bus.stall), 0);
    // MEI beats MSI, MSI taken at the next boundary
    #1 bus.mie = 32'h808; bus.mip = 32'h8; bus.irq_ext = 1; bus.inst_boundary = 1;
    step();
    chk("t3_mei", bus.cause, 32'h8000_000B);
    #1 bus.irq_ext = 0; bus.inst_boundary = 0;
    step();
    #1 bus.trap_ack = 1;
    step();
    #1 bus.trap_ack = 0; bus.inst_boundary = 1;
    step();
    chk("t3_msi", bus.cause, 32'h8000_0003);
    #1 bus.inst_boundary = 0; bus.mip = '0; bus.trap_ack = 1;
    step();
    #1 bus.trap_ack = 0;
    step();
    // exception beats a simultaneous MTI
    #1 bus.mie = 32'h80; bus.mip = 32'h80; bus.inst_boundary = 1;
    bus.exc_valid = 1; bus.exc_cause = 32'd5; bus.exc_badaddr = 32'hdead;
    step();
    chk("t4_exc_first", bus.cause, 32'd5);
    chk("t4_exc_bad", bus.badaddr, 32'hdead);
    #1 bus.exc_valid = 0; bus.inst_boundary = 0;
    step();
    #1 bus.trap_ack = 1;
    step();
    #1 bus.trap_ack = 0; bus.inst_boundary = 1;
    step();
    chk("t4_mti_after", bus.cause, 32'h8000_0007);
    chk("t4_mti_bad", bus.badaddr, 0);
    #1 bus.inst_boundary = 0; bus.mip = '0; bus.trap_ack = 1;
    step();
    #1 bus.trap_ack = 0;
    step();
    // WFI with MIE clear: wakes on pending, no trap
    #1 bus.mstatus = '0; bus.mie = 32'h80; bus.inst_boundary = 1; bus.wfi_req = 1;
    step();
    chk("t5_wfi", 32'(bus.wfi_active), 1);
    chk("t5_stall", 32'(bus.stall), 1);
    #1 bus.wfi_req = 0;
    step(); step(); step();
    chk("t5_asleep", 32'(bus.wfi_active), 1);
    #1 bus.mip = 32'h80;
    step();
    chk("t5_wake", 32'(bus.wfi_active), 0);
    chk("t5_no_event", 32'(bus.exception_event), 0);
    step();
    chk("t5_still_no_event", 32'(bus.exception_event), 0);
    // WFI with interrupt already pending: one cycle asleep
    #1 bus.wfi_req = 1;
    step();
    chk("t5b_enter", 32'(bus.wfi_active), 1);
    #1 bus.wfi_req = 0;
    step();
    chk("t5b_exit", 32'(bus.wfi_active), 0);
    // user mode enables interrupts regardless of MIE
    #1 bus.privilege_mode = 2'd0;
    step();
    chk("t5c_user_irq", bus.cause, 32'h8000_0007);
    #1 bus.inst_boundary = 0; bus.mip = '0; bus.privilege_mode = 2'd3; bus.trap_ack = 1;
    step();
    #1 bus.trap_ack = 0;
    step();
    // interrupt that drops before its boundary is never issued
    #1 bus.mstatus = 32'h8; bus.mip = 32'h80;
    step(); step();
    #1 bus.mip = '0; bus.inst_boundary = 1;
    step();
    chk("t8_dropped_irq", 32'(bus.exception_event), 0);
    // exception and WFI together: WFI dropped
    #1 bus.inst_boundary = 0; bus.exc_valid = 1; bus.wfi_req = 1; bus.exc_cause = 32'd7; bus.exc_badaddr = 32'h40;
    step();
    chk("t7_event", 32'(bus.exception_event), 1);
    chk("t7_no_wfi", 32'(bus.wfi_active), 0);
    #1 bus.exc_valid = 0; bus.wfi_req = 0; bus.trap_ack = 1;
    step();
    #1 bus.trap_ack = 0;
    step();
    chk("t7_idle", 32'(bus.wfi_active | bus.stall), 0);
    // asynchronous reset while waiting for ack
    #1 bus.exc_valid = 1; bus.exc_cause = 32'd4;
    step();
    #1 bus.exc_valid = 0;
    step();
    chk("t6_waiting", 32'(bus.stall), 1);
    #1 resetn = 0;
    #1;
    chk("t6_stall", 32'(bus.stall), 0);
    chk("t6_cause", bus.cause, 0);
    step();
    #1 resetn = 1;
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
